adc_scan_seq: RTL and testbench

Parametrised SPI sequencer for MCP300x-family SAR ADCs. It scans a run-time channel mask and emits one tagged result per conversion. It replaces the fixed single-channel, slow-tick ADC readout in board tops and derives its own SPI clock from `clk`. It feeds display, framebuffer or FFT consumers through a one-cycle valid strobe.

---
 rtl/adc_seq_pkg.sv | 47 ++++
 rtl/adc_sclk_gen.sv | 39 +++
 rtl/adc_scan_seq.sv | 215 +++++++++++++++++++++
 tb/tb_adc_scan_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// ---------------------------------------------------------------------------
// adc_seq_pkg
// Shared types and helpers for the MCP300x scan sequencer.
//   seqState_t    : sequencer states (IDLE, FRAME, GAP)
//   START_BIT     : value of the leading command bit
//   HDR_RISES     : SPI rising edges before the first data bit
//                   (start, SGL/DIFF, D2, D1, D0, null)
//   frameEndTick  : half-period index at which a frame closes
//   nextChannel   : round-robin search for the next enabled channel
// ---------------------------------------------------------------------------
package adc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FRAME,
    GAP
  } seqState_t;

  localparam logic START_BIT = 1'b1;
  localparam int   HDR_RISES = 6;

  // One frame is HDR_RISES + resBits full SPI periods, two ticks each.
  function automatic int frameEndTick(input int resBits);
    return 2 * (HDR_RISES + resBits);
  endfunction

  // Searches the mask upward from cur with 3-bit wraparound. With
  // inclusive set, cur itself is a candidate (used when leaving IDLE so a
  // still-enabled pointer is honoured); otherwise the search starts at
  // cur+1 and reaches cur last. An empty mask leaves the pointer alone.
  function automatic logic [2:0] nextChannel(input logic [7:0] mask,
                                             input logic [2:0] cur,
                                             input logic       inclusive);
    logic [2:0] idx;
    logic       found;
    nextChannel = cur;
    found       = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = cur + 3'(i) + (inclusive ? 3'd0 : 3'd1);
      if (!found && mask[idx]) begin
        nextChannel = idx;
        found       = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// ---------------------------------------------------------------------------
// adc_sclk_gen
// Half-period tick generator for the SPI clock.
//   clk       in  : system clock
//   rst_n     in  : asynchronous active-low reset
//   i_run     in  : counter advances while high, held at zero while low
//   i_restart in  : forces the phase back to zero
//   o_tick    out : one-cycle pulse every CLK_DIV cycles while running
// ---------------------------------------------------------------------------
module adc_sclk_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_restart,
  output logic o_tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;

  // Counter sits at zero whenever stopped, so the first tick after a start
  // always lands exactly CLK_DIV cycles later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_restart || !i_run || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tick = i_run && (r_cnt == LAST);

endmodule

// File: rtl/adc_scan_seq.sv
// ---------------------------------------------------------------------------
// adc_scan_seq
// SPI sequencer for MCP300x-family SAR ADCs. Scans the enabled channels in
// round-robin order and emits one tagged result per conversion.
//   clk, rst_n    : system clock, asynchronous active-low reset
//   enable        : scanning runs while high
//   ch_mask       : channels to scan (sampled at the end of each frame)
//   AD_CLK        : SPI clock, idle low
//   CS            : ADC chip select, active low
//   DIN           : command bits to the ADC
//   DOUT          : conversion data from the ADC
//   sample_data   : last result
//   sample_ch     : channel of sample_data
//   sample_valid  : one-cycle strobe for a new result
//   busy          : high while CS is low
// Build option: define ADC_AVG_EN to average 2^AVG_LOG2 conversions per
// channel before a result is emitted. The AVG_LOG2 parameter only exists in
// that build.
// ---------------------------------------------------------------------------
module adc_scan_seq
  import adc_seq_pkg::*;
#(
  parameter int CLK_DIV      = 2,
  parameter int NUM_CH       = 8,
  parameter int RES_BITS     = 10,
  parameter int SINGLE_ENDED = 1,
  parameter int CSH_TICKS    = 2
`ifdef ADC_AVG_EN
  ,
  parameter int AVG_LOG2     = 2
`endif
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [NUM_CH-1:0]   ch_mask,
  output logic                AD_CLK,
  output logic                CS,
  output logic                DIN,
  input  logic                DOUT,
  output logic [RES_BITS-1:0] sample_data,
  output logic [2:0]          sample_ch,
  output logic                sample_valid,
  output logic                busy
);

  localparam int E_TICK  = frameEndTick(RES_BITS);
  localparam int CNT_MAX = (E_TICK > CSH_TICKS) ? E_TICK : CSH_TICKS;
  localparam int TW      = $clog2(CNT_MAX + 1);

  seqState_t           r_state, w_stateNxt;
  logic                w_tick, w_frameStart, w_endTick, w_maskAny;
  logic [TW-1:0]       r_tickIdx, w_k;
  logic [2:0]          r_ptr, w_startCh, w_nextCh;
  logic [3:0]          r_cmd;
  logic [RES_BITS-1:0] r_shift, r_data;
  logic [7:0]          w_mask8;
  logic                r_sclk, r_cs, r_din, r_valid;
  logic [2:0]          r_ch;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_run     (r_state != IDLE),
    .i_restart (w_frameStart && (r_state == IDLE)),
    .o_tick    (w_tick)
  );

  assign w_mask8   = 8'(ch_mask);
  assign w_maskAny = |ch_mask;
  assign w_k       = r_tickIdx + 1'b1;
  assign w_startCh = (r_state == IDLE) ? nextChannel(w_mask8, r_ptr, 1'b1) : r_ptr;
  assign w_nextCh  = nextChannel(w_mask8, r_ptr, 1'b0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNxt;
  end

  // w_k is the index of the tick being applied this cycle; r_tickIdx counts
  // frame ticks in FRAME and CS-high ticks in GAP.
  always_comb begin
    w_stateNxt   = r_state;
    w_frameStart = 1'b0;
    w_endTick    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && w_maskAny) begin
          w_stateNxt   = FRAME;
          w_frameStart = 1'b1;
        end
      end
      FRAME: begin
        if (w_tick && (w_k == TW'(E_TICK))) begin
          w_stateNxt = GAP;
          w_endTick  = 1'b1;
        end
      end
      GAP: begin
        if (w_tick && (w_k == TW'(CSH_TICKS))) begin
          if (enable && w_maskAny) begin
            w_stateNxt   = FRAME;
            w_frameStart = 1'b1;
          end else begin
            w_stateNxt = IDLE;
          end
        end
      end
      default: w_stateNxt = IDLE;
    endcase
  end

  // SPI frame datapath. Frame start is tick 0: CS drops and the start bit
  // goes out. DOUT is shifted on every rising edge; only the last RES_BITS
  // shifts survive, so the command and null-bit edges fall out naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs      <= 1'b1;
      r_sclk    <= 1'b0;
      r_din     <= 1'b0;
      r_tickIdx <= '0;
      r_ptr     <= '0;
      r_cmd     <= '0;
      r_shift   <= '0;
    end else if (w_frameStart) begin
      r_cs      <= 1'b0;
      r_sclk    <= 1'b0;
      r_din     <= START_BIT;
      r_tickIdx <= '0;
      r_ptr     <= w_startCh;
      r_cmd     <= {1'(SINGLE_ENDED), w_startCh};
    end else if (w_tick) begin
      r_tickIdx <= w_endTick ? '0 : w_k;
      if (r_state == FRAME) begin
        if (w_k[0]) begin
          r_sclk  <= 1'b1;
          r_shift <= {r_shift[RES_BITS-2:0], DOUT};
        end else begin
          r_sclk <= 1'b0;
          r_din  <= r_cmd[3];
          r_cmd  <= {r_cmd[2:0], 1'b0};
        end
        if (w_endTick) begin
          r_cs  <= 1'b1;
          r_ptr <= w_nextCh;
        end
      end
    end
  end

`ifdef ADC_AVG_EN
  localparam int            AW       = RES_BITS + AVG_LOG2;
  localparam int            NW       = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [NW-1:0] SET_LAST = NW'((1 << AVG_LOG2) - 1);

  logic [AW-1:0] r_acc [NUM_CH];
  logic [NW-1:0] r_num [NUM_CH];
  logic [AW-1:0] w_sum;

  assign w_sum = r_acc[r_ptr] + AW'(r_shift);
`endif

  // Result register. In the averaging build a channel whose mask bit is low
  // has its partial set discarded, and that clear wins over a same-cycle add.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
`ifdef ADC_AVG_EN
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_num[i] <= '0;
      end
`endif
    end else begin
      r_valid <= 1'b0;
`ifdef ADC_AVG_EN
      if (w_endTick) begin
        if (r_num[r_ptr] == SET_LAST) begin
          r_valid      <= 1'b1;
          r_data       <= RES_BITS'(w_sum >> AVG_LOG2);
          r_ch         <= r_ptr;
          r_acc[r_ptr] <= '0;
          r_num[r_ptr] <= '0;
        end else begin
          r_acc[r_ptr] <= w_sum;
          r_num[r_ptr] <= r_num[r_ptr] + 1'b1;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (!ch_mask[i]) begin
          r_acc[i] <= '0;
          r_num[i] <= '0;
        end
      end
`else
      if (w_endTick) begin
        r_valid <= 1'b1;
        r_data  <= r_shift;
        r_ch    <= r_ptr;
      end
`endif
    end
  end

  assign AD_CLK       = r_sclk;
  assign CS           = r_cs;
  assign DIN          = r_din;
  assign busy         = ~r_cs;
  assign sample_valid = r_valid;
  assign sample_data  = r_data;
  assign sample_ch    = r_ch;

endmodule

// File: tb/tb_adc_scan_seq.sv
// ---------------------------------------------------------------------------
// tb_adc_scan_seq
// Self-checking bench for adc_scan_seq. An MCP3008-like ADC model decodes the
// command on AD_CLK rises and returns a chosen or random conversion; expected
// channels come from the round-robin scan rule applied to the mask.
// ---------------------------------------------------------------------------
module tb_adc_scan_seq;

  localparam int DIV       = 2;
  localparam int NCH       = 8;
  localparam int RES       = 10;
  localparam int SGL       = 1;
  localparam int CSH       = 2;
  localparam int E_TICKS   = 2 * (6 + RES);
  localparam int FRAME_CLK = (E_TICKS + CSH) * DIV;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic [NCH-1:0] ch_mask = '0;
  logic           AD_CLK, CS, DIN;
  logic           DOUT = 1'b0;
  logic [RES-1:0] sample_data;
  logic [2:0]     sample_ch;
  logic           sample_valid, busy;

  int errCount = 0;
  int checkCount = 0;
  int cyc = 0;
  int lastSize = 0;

  // ADC model controls, written only by the main sequence
  bit useFixed = 1'b0;
  int fixedVal = 0;
  int fixedStep = 0;
  int fixedBase = 0;

  // ADC model results: one entry per completed frame
  logic [RES-1:0] adcVals[$];
  logic [4:0]     adcCmds[$];

  typedef struct {
    logic [7:0]     mask;
    logic [RES-1:0] adcVal;
    int             expCh;
    int             expCh2;
  } vec_t;
  vec_t vecs[4];

  adc_scan_seq #(
    .CLK_DIV(DIV), .NUM_CH(NCH), .RES_BITS(RES),
    .SINGLE_ENDED(SGL), .CSH_TICKS(CSH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ch_mask(ch_mask),
    .AD_CLK(AD_CLK), .CS(CS), .DIN(DIN), .DOUT(DOUT),
    .sample_data(sample_data), .sample_ch(sample_ch),
    .sample_valid(sample_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: watches SPI lines on the falling clk edge, captures five
  // command bits on AD_CLK rises, then presents data MSB first after the
  // null bit so each bit is stable before the rise that samples it.
  int             riseCnt = 0;
  logic [4:0]     cmdBits = '0;
  logic [RES-1:0] curVal = '0;
  logic           prevCs = 1'b1;
  logic           prevSclk = 1'b0;

  always @(negedge clk) begin
    if (prevCs && !CS) begin
      riseCnt = 0;
      cmdBits = '0;
      if (useFixed) curVal = RES'(fixedVal + fixedStep * (adcVals.size() - fixedBase));
      else          curVal = RES'($urandom_range(0, (1 << RES) - 1));
      DOUT = 1'b0;
    end
    if (!CS && !prevSclk && AD_CLK) begin
      riseCnt++;
      if (riseCnt <= 5) cmdBits = {cmdBits[3:0], DIN};
    end
    if (!CS && prevSclk && !AD_CLK && riseCnt >= 6 && riseCnt < 6 + RES)
      DOUT = curVal[RES - 1 - (riseCnt - 6)];
    if (!prevCs && CS && riseCnt == 6 + RES) begin
      adcVals.push_back(curVal);
      adcCmds.push_back(cmdBits);
    end
    prevCs   = CS;
    prevSclk = AD_CLK;
  end

  // Scan rule: the next set bit above cur, wrapping; inclusive also accepts cur.
  function automatic int refScan(input logic [7:0] mask, input int cur, input bit inclusive);
    for (int d = (inclusive ? 0 : 1); d <= 8; d++)
      if (mask[3'((cur + d) % 8)]) return (cur + d) % 8;
    return cur;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] mask, input logic en);
    ch_mask = mask;
    enable  = en;
  endtask

  task automatic doReset();
    applyStimulus(8'h00, 1'b0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    lastSize = adcVals.size();
  endtask

  task automatic waitStrobe(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (sample_valid) seen = 1'b1;
    end
    #1;
  endtask

  task automatic waitCsLow(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (!CS) seen = 1'b1;
    end
  endtask

  task automatic checkResult(input string tag, input bit seen, input int expCh);
    checkOutput({tag, "Seen"}, 32'(seen), 1);
    if (seen) begin
      checkOutput({tag, "Frame"}, adcVals.size(), lastSize + 1);
      lastSize = adcVals.size();
      if (adcVals.size() > 0) begin
        checkOutput({tag, "Ch"}, sample_ch, expCh);
        checkOutput({tag, "Data"}, sample_data, adcVals[$]);
        checkOutput({tag, "Cmd"}, adcCmds[$], {1'b1, 1'(SGL), 3'(expCh)});
      end
    end
  endtask

  initial begin
    bit   seen;
    int   cnt, t1, strobes, csLows, expCh;
    logic [7:0] mask;

    vecs[0] = '{mask: 8'h01, adcVal: 10'h2A5, expCh: 0, expCh2: 0};
    vecs[1] = '{mask: 8'h08, adcVal: 10'h3FF, expCh: 3, expCh2: 3};
    vecs[2] = '{mask: 8'h80, adcVal: 10'h000, expCh: 7, expCh2: 7};
    vecs[3] = '{mask: 8'h30, adcVal: 10'h155, expCh: 4, expCh2: 5};

    // Reset held with the inputs asking for a scan: nothing may move.
    applyStimulus(8'hFF, 1'b1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("rstCs", CS, 1);
      checkOutput("rstSclk", AD_CLK, 0);
      checkOutput("rstBusy", busy, 0);
    end
    checkOutput("rstDin", DIN, 0);
    checkOutput("rstValid", sample_valid, 0);
    checkOutput("rstData", sample_data, 0);
    checkOutput("rstCh", sample_ch, 0);

`ifndef ADC_AVG_EN
    // Table-driven single-channel frames with fixed ADC values.
    for (int v = 0; v < 4; v++) begin
      doReset();
      useFixed  = 1'b1;
      fixedVal  = int'(vecs[v].adcVal);
      fixedStep = 0;
      applyStimulus(vecs[v].mask, 1'b1);
      @(negedge clk);
      checkOutput("csLatency", CS, 0);
      cnt = 0;
      while (!AD_CLK && cnt < 4 * DIV) begin
        @(negedge clk);
        cnt++;
      end
      checkOutput("firstRise", cnt, DIV);
      waitStrobe(2 * FRAME_CLK, seen);
      checkResult("vec", seen, vecs[v].expCh);
      t1 = cyc;
      cnt = 0;
      while (CS && cnt < 4 * FRAME_CLK) begin
        @(negedge clk);
        cnt++;
      end
      checkOutput("gapLen", cnt, CSH * DIV);
      waitStrobe(2 * FRAME_CLK, seen);
      checkResult("vec2", seen, vecs[v].expCh2);
      checkOutput("period", cyc - t1, FRAME_CLK);
    end

    // Scan order with random conversions: the fixed mask first, then random masks.
    useFixed = 1'b0;
    for (int m = 0; m < 4; m++) begin
      mask = (m == 0) ? 8'h85 : 8'($urandom_range(1, 255));
      doReset();
      applyStimulus(mask, 1'b1);
      expCh = refScan(mask, 0, 1'b1);
      for (int s = 0; s < 5; s++) begin
        waitStrobe(2 * FRAME_CLK, seen);
        checkResult("scan", seen, expCh);
        expCh = refScan(mask, expCh, 1'b0);
      end
    end

    // Enable falls at tick 10: the frame still finishes and reports, then idle.
    doReset();
    applyStimulus(8'h01, 1'b1);
    waitCsLow(8, seen);
    checkOutput("dropStart", 32'(seen), 1);
    repeat (10 * DIV) @(negedge clk);
    applyStimulus(8'h01, 1'b0);
    waitStrobe(2 * FRAME_CLK, seen);
    checkResult("drop", seen, 0);
    strobes = 0;
    csLows = 0;
    for (int i = 0; i < 3 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (!CS) csLows++;
      if (sample_valid) strobes++;
    end
    checkOutput("dropCsLows", csLows, 0);
    checkOutput("dropStrobes", strobes, 0);
    checkOutput("dropBusy", busy, 0);

    // Asynchronous reset mid-frame, taken while AD_CLK is high (tick 21).
    doReset();
    applyStimulus(8'h02, 1'b1);
    waitCsLow(8, seen);
    checkOutput("arstStart", 32'(seen), 1);
    repeat (21 * DIV) @(negedge clk);
    checkOutput("arstSclkHigh", AD_CLK, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arstCs", CS, 1);
    checkOutput("arstSclk", AD_CLK, 0);
    checkOutput("arstBusy", busy, 0);
    applyStimulus(8'h00, 1'b0);
    strobes = 0;
    repeat (3) begin
      @(negedge clk);
      if (sample_valid) strobes++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      @(negedge clk);
      if (sample_valid) strobes++;
    end
    checkOutput("arstStrobes", strobes, 0);
    checkOutput("arstFrames", adcVals.size(), lastSize);
`else
    // Averaging: channel 3 returns 100..103; one strobe carries the floor mean.
    doReset();
    useFixed  = 1'b1;
    fixedBase = adcVals.size();
    fixedVal  = 100;
    fixedStep = 1;
    applyStimulus(8'h08, 1'b1);
    waitStrobe(6 * FRAME_CLK, seen);
    checkOutput("avgSeen", 32'(seen), 1);
    checkOutput("avgFrames", adcVals.size() - fixedBase, 4);
    cnt = 0;
    for (int i = 0; i < 4; i++) cnt += 100 + i;
    checkOutput("avgCh", sample_ch, 3);
    checkOutput("avgData", sample_data, cnt / 4);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
